// File: rtl/audio_pkg.sv
// Shared constants for the I2S capture path: FSM state codes, default widths
// and the channel-tag width helper.
package audio_pkg;

    localparam int unsigned DEF_SAMPLE_W = 24;
    localparam int unsigned DEF_SLOT_W   = 32;

    // Capture FSM state codes
    typedef logic [1:0] cap_state_t;
    localparam cap_state_t C_OFF   = 2'd0;
    localparam cap_state_t C_ALIGN = 2'd1;
    localparam cap_state_t C_RUN   = 2'd2;

    // Serializer FSM state codes
    typedef logic ser_state_t;
    localparam ser_state_t S_IDLE = 1'b0;
    localparam ser_state_t S_EMIT = 1'b1;

    // Width of a channel tag for n_lines stereo lines (never below 1 bit)
    function automatic int unsigned chan_idx_w(input int unsigned n_lines);
        return (n_lines == 0) ? 1 : $clog2(2 * n_lines);
    endfunction

endpackage

// File: rtl/i2s_line_deser.sv
// One I2S data line: MSB-first shift register, slot bit counter and the
// completed left/right words. The bit seen on an edge belongs to the slot of
// the previous edge's ws, so a ws change closes the old slot with this bit.
module i2s_line_deser
    import audio_pkg::*;
#(
    parameter int unsigned SAMPLE_W = DEF_SAMPLE_W,
    parameter int unsigned SLOT_W   = DEF_SLOT_W
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                edge_i,
    input  logic                ws_i,
    input  logic                ws_prev_i,
    input  logic                sd_i,
    output logic [SAMPLE_W-1:0] left_o,
    output logic [SAMPLE_W-1:0] right_o
);
    localparam int unsigned CNT_W = $clog2(SLOT_W + 1);

    logic [SAMPLE_W-1:0] shift_q, shift_d;
    logic [SAMPLE_W-1:0] left_q, left_d;
    logic [SAMPLE_W-1:0] right_q, right_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    // Shift in the first SAMPLE_W bits of a slot; store the word when ws flips
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        left_d  = left_q;
        right_d = right_q;
        if (edge_i) begin
            if (cnt_q < CNT_W'(SAMPLE_W)) begin
                shift_d = {shift_q[SAMPLE_W-2:0], sd_i};
            end
            if (ws_i != ws_prev_i) begin
                cnt_d = '0;
                if (ws_prev_i) begin
                    right_d = shift_d;
                end else begin
                    left_d = shift_d;
                end
            end else if (cnt_q != CNT_W'(SLOT_W)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // State registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shift_q <= '0;
            cnt_q   <= '0;
            left_q  <= '0;
            right_q <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            left_q  <= left_d;
            right_q <= right_d;
        end
    end

    assign left_o  = left_q;
    assign right_o = right_q;

endmodule

// File: rtl/i2s_multi_capture.sv
// Multi-line I2S capture: synchronises sck/ws/sd, deserialises N_LINES stereo
// lines, latches whole frames and streams the enabled channels through a FIFO
// with a registered output stage.
module i2s_multi_capture
    import audio_pkg::*;
#(
    parameter int unsigned N_LINES     = 2,
    parameter int unsigned SAMPLE_W    = DEF_SAMPLE_W,
    parameter int unsigned SLOT_W      = DEF_SLOT_W,
    parameter int unsigned OUT_W       = 32,
    parameter int unsigned SIGN_EXTEND = 1,
    parameter int unsigned FIFO_DEPTH  = 8
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             sck_i,
    input  logic                             ws_i,
    input  logic [N_LINES-1:0]               sd_i,
    input  logic                             enable_i,
    input  logic [2*N_LINES-1:0]             chan_mask_i,
    output logic [OUT_W-1:0]                 m_data_o,
    output logic [chan_idx_w(N_LINES)-1:0]   m_chan_o,
    output logic                             m_last_o,
    output logic                             m_valid_o,
    input  logic                             m_ready_i,
    output logic                             overflow_o,
    input  logic                             clear_overflow_i,
    output logic [15:0]                      frame_count_o
);
    localparam int unsigned N_CH  = 2 * N_LINES;
    localparam int unsigned CH_W  = chan_idx_w(N_LINES);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned FW    = OUT_W + CH_W + 1;

    logic               sck_meta_q, sck_s_q, sck_prev_q;
    logic               ws_meta_q, ws_s_q, ws_prev_q;
    logic [N_LINES-1:0] sd_meta_q, sd_s_q;
    logic               sck_edge, boundary;

    // Two-flop synchronisers plus sck history and ws as seen on the last edge
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sck_meta_q <= 1'b0; sck_s_q <= 1'b0; sck_prev_q <= 1'b0;
            ws_meta_q  <= 1'b0; ws_s_q  <= 1'b0; ws_prev_q  <= 1'b0;
            sd_meta_q  <= '0;   sd_s_q  <= '0;
        end else begin
            sck_meta_q <= sck_i; sck_s_q <= sck_meta_q; sck_prev_q <= sck_s_q;
            ws_meta_q  <= ws_i;  ws_s_q  <= ws_meta_q;
            sd_meta_q  <= sd_i;  sd_s_q  <= sd_meta_q;
            if (sck_edge) ws_prev_q <= ws_s_q;
        end
    end

    assign sck_edge = sck_s_q & ~sck_prev_q;
    assign boundary = sck_edge & ws_prev_q & ~ws_s_q;

    // Channel c = 2*line + right
    logic [SAMPLE_W-1:0] word [N_CH];

    for (genvar l = 0; l < int'(N_LINES); l++) begin : g_line
        i2s_line_deser #(
            .SAMPLE_W (SAMPLE_W),
            .SLOT_W   (SLOT_W)
        ) u_deser (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .edge_i    (sck_edge),
            .ws_i      (ws_s_q),
            .ws_prev_i (ws_prev_q),
            .sd_i      (sd_s_q[l]),
            .left_o    (word[2*l]),
            .right_o   (word[2*l+1])
        );
    end

    cap_state_t cap_q, cap_d;
    logic       latch_q, latch_d;

    // Capture FSM: align to a ws 1->0 boundary, then one latch per frame
    always_comb begin
        cap_d   = cap_q;
        latch_d = 1'b0;
        case (cap_q)
            C_OFF:   if (enable_i) cap_d = C_ALIGN;
            C_ALIGN: if (boundary) cap_d = C_RUN;
            C_RUN:   latch_d = boundary;
            default: cap_d = C_OFF;
        endcase
        if (!enable_i) begin
            cap_d   = C_OFF;
            latch_d = 1'b0;
        end
    end

    ser_state_t          ser_q, ser_d;
    logic [SAMPLE_W-1:0] hold_q [N_CH];
    logic [N_CH-1:0]     pend_q, pend_d, pend_rest;
    logic [CH_W-1:0]     sel;
    logic                found, load, ovf_set, push, full, empty, pop;
    logic [OUT_W-1:0]    push_data;

    // Lowest pending channel and what remains once it is sent
    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int c = 0; c < int'(N_CH); c++) begin
            if (pend_q[c] && !found) begin
                sel   = CH_W'(c);
                found = 1'b1;
            end
        end
        pend_rest      = pend_q;
        pend_rest[sel] = 1'b0;
    end

    // Widen the selected sample to the output word
    always_comb begin
        if (SIGN_EXTEND != 0) begin
            push_data = OUT_W'($signed(hold_q[sel]));
        end else begin
            push_data = OUT_W'(hold_q[sel]);
        end
    end

    assign push = (ser_q == S_EMIT) && !full;

    // Serializer FSM: snapshot a frame, then one enabled channel per clock
    always_comb begin
        ser_d   = ser_q;
        pend_d  = pend_q;
        load    = 1'b0;
        ovf_set = 1'b0;
        case (ser_q)
            S_IDLE: begin
                if (latch_q) begin
                    load   = 1'b1;
                    pend_d = chan_mask_i;
                    if (|chan_mask_i) ser_d = S_EMIT;
                end
            end
            default: begin
                ovf_set = latch_q;
                if (push) begin
                    pend_d = pend_rest;
                    if (pend_rest == '0) ser_d = S_IDLE;
                end
            end
        endcase
    end

    // Control state, frame counter and sticky overflow
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cap_q         <= C_OFF;
            latch_q       <= 1'b0;
            ser_q         <= S_IDLE;
            pend_q        <= '0;
            frame_count_o <= '0;
            overflow_o    <= 1'b0;
            for (int c = 0; c < int'(N_CH); c++) hold_q[c] <= '0;
        end else begin
            cap_q   <= cap_d;
            latch_q <= latch_d;
            ser_q   <= ser_d;
            pend_q  <= pend_d;
            if (latch_q) frame_count_o <= frame_count_o + 16'd1;
            if (ovf_set) begin
                overflow_o <= 1'b1;
            end else if (clear_overflow_i) begin
                overflow_o <= 1'b0;
            end
            if (load) begin
                for (int c = 0; c < int'(N_CH); c++) hold_q[c] <= word[c];
            end
        end
    end

    logic [FW-1:0]    mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   cnt_q;
    logic             out_valid_q;
    logic [FW-1:0]    out_word_q;

    assign full  = (cnt_q == (PTR_W + 1)'(FIFO_DEPTH));
    assign empty = (cnt_q == '0);
    // Refill the output register whenever it is empty or being consumed
    assign pop   = !empty && (!out_valid_q || m_ready_i);

    // FIFO storage
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= {push_data, sel, (pend_rest == '0)};
    end

    // FIFO pointers and registered output stage
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_word_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (pop && !push) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (pop) begin
                out_valid_q <= 1'b1;
                out_word_q  <= mem_q[rd_ptr_q];
            end else if (m_ready_i) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign m_valid_o = out_valid_q;
    assign m_data_o  = out_word_q[FW-1 -: OUT_W];
    assign m_chan_o  = out_word_q[CH_W:1];
    assign m_last_o  = out_word_q[0];

endmodule

// File: tb/tb_i2s_multi_capture.sv
// Bench for i2s_multi_capture: three instances share one I2S stimulus
// (defaults, SIGN_EXTEND=0, SAMPLE_W=SLOT_W=32); expected words go into
// per-instance queues and a monitor compares every accepted output word.
module tb_i2s_multi_capture;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sck = 1'b0;
    logic        ws = 1'b0;
    logic [1:0]  sd = 2'b00;
    logic        enable = 1'b0;
    logic [3:0]  mask = 4'h0;
    logic        ready = 1'b0;
    logic        clr = 1'b0;

    logic [31:0] data  [3];
    logic [1:0]  chan  [3];
    logic        last  [3];
    logic        valid [3];
    logic        ovf   [3];
    logic [15:0] fc    [3];

    always #5 clk = ~clk;

    i2s_multi_capture u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .sck_i(sck), .ws_i(ws), .sd_i(sd),
        .enable_i(enable), .chan_mask_i(mask), .m_data_o(data[0]), .m_chan_o(chan[0]),
        .m_last_o(last[0]), .m_valid_o(valid[0]), .m_ready_i(ready), .overflow_o(ovf[0]),
        .clear_overflow_i(clr), .frame_count_o(fc[0])
    );

    i2s_multi_capture #(.SIGN_EXTEND(0)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .sck_i(sck), .ws_i(ws), .sd_i(sd),
        .enable_i(enable), .chan_mask_i(mask), .m_data_o(data[1]), .m_chan_o(chan[1]),
        .m_last_o(last[1]), .m_valid_o(valid[1]), .m_ready_i(ready), .overflow_o(ovf[1]),
        .clear_overflow_i(clr), .frame_count_o(fc[1])
    );

    i2s_multi_capture #(.SAMPLE_W(32), .SLOT_W(32)) u_dut2 (
        .clk_i(clk), .rst_ni(rst_n), .sck_i(sck), .ws_i(ws), .sd_i(sd),
        .enable_i(enable), .chan_mask_i(mask), .m_data_o(data[2]), .m_chan_o(chan[2]),
        .m_last_o(last[2]), .m_valid_o(valid[2]), .m_ready_i(ready), .overflow_o(ovf[2]),
        .clear_overflow_i(clr), .frame_count_o(fc[2])
    );

    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  ch;
        logic        last;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    int   checks = 0;
    int   errors = 0;

    // Current 32-bit slot per channel (ch0 = L0, ch1 = R0, ch2 = L1, ch3 = R1)
    logic [31:0] cur [4];
    // Expected output word per instance and channel for the current frame
    logic [31:0] exp_tab [3][4];

    function automatic void chk(input string name, input int k, input logic [31:0] act,
                                input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL dut%0d %s: got %h expected %h", k, name, act, req);
        end
    endfunction

    function automatic void cmp(input int k, input exp_t e);
        chk("data", k, data[k], e.d);
        chk("chan", k, 32'(chan[k]), 32'(e.ch));
        chk("last", k, 32'(last[k]), 32'(e.last));
    endfunction

    function automatic void unexpected(input int k);
        checks++;
        errors++;
        $display("FAIL dut%0d unexpected word: got data %h chan %0d, expected none",
                 k, data[k], chan[k]);
    endfunction

    // Monitor: compare each word the DUTs hand over (valid && ready)
    always @(negedge clk) begin
        if (rst_n && ready) begin
            if (valid[0]) begin
                if (q0.size() == 0) unexpected(0); else cmp(0, q0.pop_front());
            end
            if (valid[1]) begin
                if (q1.size() == 0) unexpected(1); else cmp(1, q1.pop_front());
            end
            if (valid[2]) begin
                if (q2.size() == 0) unexpected(2); else cmp(2, q2.pop_front());
            end
        end
    end

    // Reference widening of a 32-bit slot for each instance
    task automatic model_fill();
        for (int c = 0; c < 4; c++) begin
            exp_tab[0][c] = {{8{cur[c][31]}}, cur[c][31:8]};
            exp_tab[1][c] = {8'h00, cur[c][31:8]};
            exp_tab[2][c] = cur[c];
        end
    endtask

    // Frame A with hand-computed words
    task automatic set_frame_a();
        cur[0] = 32'h123456A5; cur[1] = 32'h8000013C;
        cur[2] = 32'h7FFFFF81; cur[3] = 32'h000001FF;
        exp_tab[0][0] = 32'h00123456; exp_tab[0][1] = 32'hFF800001;
        exp_tab[0][2] = 32'h007FFFFF; exp_tab[0][3] = 32'h00000001;
        exp_tab[1][0] = 32'h00123456; exp_tab[1][1] = 32'h00800001;
        exp_tab[1][2] = 32'h007FFFFF; exp_tab[1][3] = 32'h00000001;
        exp_tab[2][0] = 32'h123456A5; exp_tab[2][1] = 32'h8000013C;
        exp_tab[2][2] = 32'h7FFFFF81; exp_tab[2][3] = 32'h000001FF;
    endtask

    task automatic set_frame_n(input int f);
        for (int c = 0; c < 4; c++) cur[c] = {4'(f), 4'(c), 16'hC0FF, 8'h11 + 8'(c)};
        model_fill();
    endtask

    task automatic push_exp(input logic [3:0] m);
        int   top;
        exp_t e;
        top = -1;
        for (int c = 0; c < 4; c++) if (m[c]) top = c;
        for (int c = 0; c < 4; c++) begin
            if (m[c]) begin
                e.ch = 2'(c); e.last = (c == top);
                e.d = exp_tab[0][c]; q0.push_back(e);
                e.d = exp_tab[1][c]; q1.push_back(e);
                e.d = exp_tab[2][c]; q2.push_back(e);
            end
        end
    endtask

    // Bits i of a 64-bit frame; ws leads data by one bit as in I2S
    task automatic send_bits(input int from, input int to);
        int idx;
        for (int i = from; i <= to; i++) begin
            idx = i % 32;
            @(posedge clk); #1;
            sck = 1'b0;
            ws  = (i >= 31 && i <= 62);
            if (i < 32) begin
                sd[0] = cur[0][31-idx]; sd[1] = cur[2][31-idx];
            end else begin
                sd[0] = cur[1][31-idx]; sd[1] = cur[3][31-idx];
            end
            repeat (3) @(posedge clk);
            #1 sck = 1'b1;
            repeat (4) @(posedge clk);
        end
    endtask

    task automatic settle();
        repeat (20) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400; i++) begin
            if (q0.size() == 0 && q1.size() == 0 && q2.size() == 0) break;
            @(posedge clk);
        end
        #1;
        chk("pending words", 0, q0.size(), 0);
        chk("pending words", 1, q1.size(), 0);
        chk("pending words", 2, q2.size(), 0);
    endtask

    task automatic check_fc(input logic [15:0] n);
        for (int k = 0; k < 3; k++) chk("frame_count", k, 32'(fc[k]), 32'(n));
    endtask

    task automatic check_ovf(input logic v);
        for (int k = 0; k < 3; k++) chk("overflow", k, 32'(ovf[k]), 32'(v));
    endtask

    task automatic check_all_zero(input string tag);
        for (int k = 0; k < 3; k++) begin
            chk({tag, " valid"}, k, 32'(valid[k]), 0);
            chk({tag, " data"}, k, data[k], 0);
            chk({tag, " chan"}, k, 32'(chan[k]), 0);
            chk({tag, " last"}, k, 32'(last[k]), 0);
        end
        check_ovf(1'b0);
        check_fc(16'd0);
    endtask

    initial begin
        #3_000_000;
        errors++;
        $display("FAIL watchdog: run did not complete, expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1; enable = 1'b1; mask = 4'hF; ready = 1'b1;

        // Alignment frame produces nothing
        for (int c = 0; c < 4; c++) cur[c] = 32'hDEADBEEF;
        send_bits(0, 63); settle();
        check_fc(16'd0);

        // Frame A, all channels
        set_frame_a(); push_exp(4'hF);
        send_bits(0, 63); settle(); wait_drain();
        check_fc(16'd1);

        // Frame A, channels 0 and 2
        mask = 4'b0101; push_exp(4'b0101);
        send_bits(0, 63); settle(); wait_drain();
        check_fc(16'd2);

        // Fully masked frame still counts
        mask = 4'b0000;
        send_bits(0, 63); settle(); wait_drain();
        check_fc(16'd3);
        check_ovf(1'b0);

        // Backpressure: frames 1-3 fill the path, frame 4 is dropped
        mask = 4'hF; ready = 1'b0;
        for (int f = 1; f <= 4; f++) begin
            set_frame_n(f);
            if (f <= 3) push_exp(4'hF);
            send_bits(0, 63); settle();
        end
        check_ovf(1'b1);
        check_fc(16'd7);
        ready = 1'b1;
        wait_drain();
        check_ovf(1'b1);
        @(posedge clk); #1 clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
        check_ovf(1'b0);

        // Enable dropped mid-left slot, back mid-right slot: partial frame lost
        set_frame_n(9);
        send_bits(0, 15);
        enable = 1'b0;
        send_bits(16, 40);
        enable = 1'b1;
        send_bits(41, 63); settle();
        check_fc(16'd7);
        set_frame_n(10); push_exp(4'hF);
        send_bits(0, 63); settle(); wait_drain();
        check_fc(16'd8);

        // Asynchronous reset while the serializer is stalled with words queued
        ready = 1'b0;
        for (int f = 11; f <= 13; f++) begin
            set_frame_n(f);
            send_bits(0, 63); settle();
        end
        for (int k = 0; k < 3; k++) chk("queued before reset", k, 32'(valid[k]), 1);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("async reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1; ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) chk("empty after reset", k, 32'(valid[k]), 0);

        // Recovery: align then frame A
        for (int c = 0; c < 4; c++) cur[c] = 32'h0F0F0F0F;
        send_bits(0, 63); settle();
        set_frame_a(); push_exp(4'hF);
        send_bits(0, 63); settle(); wait_drain();
        check_fc(16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2s_multi_capture.md
Name: i2s_multi_capture

Overview:
- Parametrised successor to the single-line 24-bit I2S capture path: deserialises N_LINES I2S data lines (stereo each) that share one sck/ws pair.
- Each completed frame is latched and its enabled channels are serialised into a tagged valid/ready stream through an output FIFO.
- Sits between the I2S clock generator and the RAM buffer. Adds channel masking, a frame counter and overflow detection.

Parameters:
- N_LINES, 2, number of sd data lines; 2*N_LINES channels.
- SAMPLE_W, 24, captured bits per slot, MSB-first.
- SLOT_W, 32, sck bits per slot. SAMPLE_W <= SLOT_W.
- OUT_W, 32, output word width. OUT_W >= SAMPLE_W.
- SIGN_EXTEND, 1, 1 = sign-extend to OUT_W; 0 = zero-pad.
- FIFO_DEPTH, 8, output FIFO entries, power of 2.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- sck_i  in  1  I2S bit clock (asynchronous, oversampled)
- ws_i  in  1  word select; 0 = left, 1 = right
- sd_i  in  N_LINES  serial data, one bit per line
- enable_i  in  1  capture enable
- chan_mask_i  in  2*N_LINES  bit c enables channel c = 2*line + (right ? 1 : 0)
- m_data_o  out  OUT_W  sample word
- m_chan_o  out  $clog2(2*N_LINES)  channel tag
- m_last_o  out  1  last enabled channel of the frame
- m_valid_o  out  1  stream valid
- m_ready_i  in  1  stream ready
- overflow_o  out  1  sticky frame-drop flag
- clear_overflow_i  in  1  clears overflow_o
- frame_count_o  out  16  latched-frame counter, wraps

Behaviour:
- Reset: all outputs 0; FIFO empty; both FSMs in their first state.
- Input sync: sck_i, ws_i and sd_i pass through 2-FF synchronisers.
  - An sck rising edge is detected when synced sck is 1 and was 0 on the previous clock (1-cycle detect).
  - All capture actions occur only on detected rising edges.
- Bit ownership: the sd bit sampled on an edge belongs to the slot given by ws as sampled on the previous edge.
  - A ws change resets the slot bit counter. The MSB is the first bit after the change.
  - Bits 0..SAMPLE_W-1 shift in; the remaining bits are ignored.
- Capture FSM:
  - C_OFF: no capture. Go to C_ALIGN when enable_i=1.
  - C_ALIGN: discard data. Go to C_RUN on an edge where prev ws=1 and current ws=0 (frame boundary).
  - C_RUN: capture. On each frame boundary edge, the complete left+right words of all lines become a frame and latch_pulse fires on the next clock.
  - enable_i=0 in any state: go to C_OFF immediately and discard the partial frame. The FIFO keeps its contents and drains normally.
- Each latch_pulse increments frame_count_o (mod 2^16), including frames that are dropped or fully masked.
- Serializer FSM:
  - S_IDLE: on latch_pulse, copy the frame into the holding register, snapshot chan_mask_i, and go to S_EMIT if the mask is nonzero.
  - S_EMIT: push the next enabled channel in ascending order, one per clock, only while the FIFO is not full (stalls otherwise). After pushing the highest enabled channel (pushed with last=1), return to S_IDLE.
  - latch_pulse while in S_EMIT: drop the new frame and set overflow_o.
- overflow_o: set has priority over clear_overflow_i when both occur in the same cycle.
- Width: data = SAMPLE_W sample, sign-extended or zero-padded to OUT_W per SIGN_EXTEND.
- Latency: the first word appears on m_valid_o 3 clocks after latch_pulse (holding load, FIFO write, registered output).
- FIFO: standard valid/ready. The word is stable while m_valid_o=1 and m_ready_i=0. A simultaneous push and pop when full is not allowed; the serializer sees full and stalls.
- Mask changes take effect at the next frame snapshot only.

Decomposition:
- audio_pkg: capture-state enum (C_OFF, C_ALIGN, C_RUN), serializer-state enum (S_IDLE, S_EMIT), chan_idx width function, default SAMPLE_W/SLOT_W constants.
- Sub-module i2s_line_deser: per-line shift register, bit counter and left/right word registers; instantiated N_LINES times.
- The FIFO reuses the existing sync FIFO if its parameters fit; otherwise it is inline.

Test Plan:
- Defaults, mask=4'b1111, frame L0=0x123456, R0=0x800001, L1=0x7FFFFF, R1=0x000001 -> 4 words 0x00123456/ch0, 0xFF800001/ch1, 0x007FFFFF/ch2, 0x00000001/ch3, last only on ch3; frame_count_o=1.
- mask=4'b0101, same frame -> 2 words, ch0 then ch2, last on ch2; mask=0 -> no words, frame_count_o still increments, overflow_o=0.
- m_ready_i=0 for 4 frames, FIFO_DEPTH=8 -> overflow_o=1 after frame 4. Releasing ready yields 12 words from frames 1-3 in order, with frame 4 absent. clear_overflow_i -> 0.
- enable_i dropped mid-left slot, then reasserted mid-frame -> no partial words; the first output is the first complete frame after the next ws 1->0 boundary.
- rst_ni asserted during S_EMIT with 3 words queued -> all outputs 0 immediately (asynchronous), FIFO empty, frame_count_o=0.
- SIGN_EXTEND=0, R0=0x800001 -> 0x00800001; SAMPLE_W=SLOT_W=32 -> the LSB captured on the ws-transition edge is correct.
